rst_seq: RTL and testbench
==========================

# rst_seq

Reset sequencer: consumes the board-level clock and asynchronous active-low reset and produces a set of staged, synchronously released reset outputs for downstream blocks. Every reset output asserts asynchronously; the block releases the outputs one per stage interval in index order and then flags the system ready. It sits between the top-level clock/reset source and the design under test. It also offers a synchronous software-reset request and a saturating uptime counter.

## Interface
- `SYNC_STAGES`, default 2: flops in the reset-release synchronizer; legal values ≥ 2.
- `NUM_OUT`, default 3: number of staged reset outputs; legal values ≥ 1.
- `STAGE_DELAY`, default 8: clock cycles between consecutive releases, and the length of the software-reset hold; legal values ≥ 1.
- `CNT_W`, default 16: width of the uptime counter.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rstn`, input, 1: asynchronous, active-low reset.
- `sw_rst_req`, input, 1: synchronous one-cycle software-reset request.
- `rst_out_n`, output, `NUM_OUT`: staged active-low resets; bit 0 is released first.
- `ready`, output, 1: high once all outputs are released.
- `busy`, output, 1: high in every state except RUN.
- `uptime`, output, `CNT_W`: cycles spent in RUN; saturating.

## Operation
- **Reset values.** While `rstn` is low, regardless of clock activity:
  - `rst_out_n` = all zeros, `ready` = 0, `busy` = 1, `uptime` = 0;
  - state = HOLD, stage counter = 0, stage index = 0, synchronizer flops = 0.
- **States:**
  - **HOLD.** Wait for the synchronized reset (`srst_n`) to be high, then go to RELEASE with counter = 0 and index = 0.
  - **RELEASE.** The counter increments each cycle. When the counter reaches `STAGE_DELAY-1`:
    - set `rst_out_n[index]` to 1 and clear the counter;
    - if index = `NUM_OUT-1`, go to RUN and set `ready` to 1 on the same edge;
    - otherwise increment the index.
  - **RUN.** `uptime` increments each cycle and stops at all ones. If `sw_rst_req` = 1:
    - on the next edge, all `rst_out_n` go to 0, `ready` goes to 0 and `uptime` goes to 0;
    - go to SW_HOLD with counter = 0.
  - **SW_HOLD.** Hold for `STAGE_DELAY` cycles, then go to RELEASE with counter = 0 and index = 0.
- `sw_rst_req` is ignored in HOLD, RELEASE and SW_HOLD.
- Once released, a `rst_out_n` bit never falls except through `rstn` or a software reset.
- `uptime` arithmetic is unsigned and saturates at 2^`CNT_W`-1; it never wraps.
- **`rstn` falling in any state** forces the reset values immediately. Release restarts from HOLD.
- **`rstn` glitch shorter than one cycle** still clears the synchronizer, so the full sequence restarts.

## Timing
- Edge 1 is the first rising `clk` edge with `rstn` high.
- `srst_n` is high after edge `SYNC_STAGES`. HOLD leaves on edge `SYNC_STAGES`+1, so the stage counter first counts at that edge.
- `rst_out_n[i]` rises at edge `SYNC_STAGES` + (i+1)·`STAGE_DELAY`. With defaults: bit 0 at 10, bit 1 at 18, bit 2 at 26.
- `ready` rises at the same edge as `rst_out_n[NUM_OUT-1]`.
- `uptime` = 1 one edge after `ready` rises.
- A `sw_rst_req` sampled at edge E in RUN:
  - outputs go low after edge E;
  - RELEASE is entered at E+`STAGE_DELAY`;
  - `rst_out_n[i]` rises at E+(i+2)·`STAGE_DELAY`. With defaults: E+16, E+24, E+32.
- All outputs are registered. There is no combinational path from inputs to outputs, except the asynchronous clear from `rstn`.

## Structure
- Package `rst_seq_pkg` holds:
  - the state enum (HOLD, RELEASE, RUN, SW_HOLD), 2-bit encoding;
  - state-width constants;
  - elaboration-time parameter legality checks.
- Sub-module `rst_sync`: `SYNC_STAGES`-deep asynchronous-assert / synchronous-deassert synchronizer (`clk`, `rstn` → `srst_n`). It is reused elsewhere for per-domain reset synchronization.
- The FSM, stage counter, index and uptime counter all live in `rst_seq`.

## Test plan
1. **Power-on sequence.** Defaults; `rstn` low for 10 cycles, then high. Expected:
   - `rst_out_n` = 3'b000 until edge 10;
   - 3'b001 at 10, 3'b011 at 18, 3'b111 at 26;
   - `ready` = 1 at edge 26, `busy` = 0 from then on.
2. **Software reset.** One-cycle `sw_rst_req` at edge 40 in RUN. Expected:
   - `rst_out_n` = 0, `ready` = 0, `uptime` = 0 after edge 40;
   - bits release at edges 56, 72 and 88 minus the delta, i.e. 56, 64, 72;
   - `ready` at 72.
3. **Ignored request.** `sw_rst_req` held high during RELEASE. Expected: the release edges are unchanged from scenario 1.
4. **Mid-sequence reset.** `rstn` pulses low between clock edges at cycle 15, between the bit 0 and bit 1 releases. Expected:
   - all outputs return to reset values immediately, with no clock edge needed;
   - the sequence restarts with the same relative timing.
5. **Saturation.** `CNT_W`=4, let RUN last 20 cycles. Expected: `uptime` reaches 15 and holds at 15.
6. **Minimum configuration.** `NUM_OUT`=1, `STAGE_DELAY`=1, `SYNC_STAGES`=2. Expected: `rst_out_n[0]` and `ready` rise at edge 3.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types, width helpers and configuration checks for the reset sequencer.
package rst_seq_pkg;

  localparam int unsigned STATE_W         = 2;
  localparam int unsigned MIN_SYNC_STAGES = 2;

  typedef enum logic [STATE_W-1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    SW_HOLD = 2'd3
  } state_e;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit cfg_legal(input int unsigned sync_stages,
                                   input int unsigned num_out,
                                   input int unsigned stage_delay,
                                   input int unsigned cnt_w);
    return (sync_stages >= MIN_SYNC_STAGES) && (num_out >= 1) &&
           (stage_delay >= 1) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Asynchronous-assert / synchronous-deassert reset synchronizer, SYNC_STAGES deep.
module rst_sync
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  output logic srst_n
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_cfg
    $error("rst_sync: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign srst_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer: releases rst_out_n one bit per STAGE_DELAY cycles,
// then flags ready; supports a software reset and a saturating uptime counter.
//
// state   | meaning
// --------+------------------------------------------------------------
// HOLD    | waiting for the synchronized board reset to deassert
// RELEASE | counting stage intervals, releasing one output per interval
// RUN     | all outputs released, uptime counting, sw reset accepted
// SW_HOLD | software reset active, holding for STAGE_DELAY cycles
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_OUT     = 3,
  parameter int unsigned STAGE_DELAY = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               ready,
  output logic               busy,
  output logic [CNT_W-1:0]   uptime
);

  if (!cfg_legal(SYNC_STAGES, NUM_OUT, STAGE_DELAY, CNT_W)) begin : g_bad_cfg
    $error("rst_seq: illegal parameter combination");
  end

  localparam int unsigned      DLY_W    = width_of(STAGE_DELAY);
  localparam int unsigned      IDX_W    = width_of(NUM_OUT);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUT - 1);

  logic srst_n;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk   (clk),
    .rstn  (rstn),
    .srst_n(srst_n)
  );

  state_e             state_q;
  logic [DLY_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_OUT-1:0] rst_out_q;
  logic               ready_q;
  logic               busy_q;
  logic [CNT_W-1:0]   uptime_q;

  logic [DLY_W-1:0]   step_cnt;
  logic [IDX_W-1:0]   step_idx;
  logic               stage_done;
  logic               last_stage;
  logic [NUM_OUT-1:0] stage_mask;

  // The edge that leaves HOLD already counts as the first release-interval
  // cycle, so HOLD evaluates the stage step as if counter and index were zero.
  always_comb begin
    step_cnt = cnt_q;
    step_idx = idx_q;
    if (state_q == HOLD) begin
      step_cnt = '0;
      step_idx = '0;
    end
    stage_done = (step_cnt == DLY_LAST);
    last_stage = (step_idx == IDX_LAST);
    stage_mask = NUM_OUT'(1) << step_idx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
      uptime_q  <= '0;
    end else begin
      unique case (state_q)
        HOLD, RELEASE: begin
          if ((state_q == RELEASE) || srst_n) begin
            state_q <= RELEASE;
            if (stage_done) begin
              rst_out_q <= rst_out_q | stage_mask;
              cnt_q     <= '0;
              if (last_stage) begin
                state_q <= RUN;
                idx_q   <= '0;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                idx_q <= step_idx + 1'b1;
              end
            end else begin
              cnt_q <= step_cnt + 1'b1;
              idx_q <= step_idx;
            end
          end
        end

        RUN: begin
          if (sw_rst_req) begin
            state_q   <= SW_HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            uptime_q  <= '0;
          end else if (uptime_q != '1) begin
            uptime_q <= uptime_q + 1'b1;
          end
        end

        SW_HOLD: begin
          if (cnt_q == DLY_LAST) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= HOLD;
        end
      endcase
    end
  end

  assign rst_out_n = rst_out_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign uptime    = uptime_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: three configurations driven in parallel, checked every
// cycle against an edge-count model plus directed literal expectations.
module tb_rst_seq;

  logic clk = 1'b0;
  logic rstn;
  logic sw_rst_req;

  logic [2:0]  ro_a, ro_s;
  logic [0:0]  ro_m;
  logic        rdy_a, rdy_s, rdy_m;
  logic        bsy_a, bsy_s, bsy_m;
  logic [15:0] up_a, up_m;
  logic [3:0]  up_s;

  int tests = 0;
  int fails = 0;
  int e     = 0;
  bit chk_en = 1'b0;

  // Per-DUT configuration: A = defaults, S = CNT_W 4, M = minimum config.
  localparam int SYNC = 2;
  int    P_N[3] = '{3, 3, 1};
  int    P_D[3] = '{8, 8, 1};
  int    P_W[3] = '{16, 4, 16};
  string NM[3]  = '{"A", "S", "M"};

  // Model: n = edges since rstn went high; bit i releases at base+(i+1)*D.
  int n_m[3]    = '{0, 0, 0};
  int base_m[3] = '{SYNC, SYNC, SYNC};

  always #5 clk = ~clk;

  rst_seq dut_a (
    .clk(clk), .rstn(rstn), .sw_rst_req(sw_rst_req),
    .rst_out_n(ro_a), .ready(rdy_a), .busy(bsy_a), .uptime(up_a)
  );

  rst_seq #(.CNT_W(4)) dut_s (
    .clk(clk), .rstn(rstn), .sw_rst_req(sw_rst_req),
    .rst_out_n(ro_s), .ready(rdy_s), .busy(bsy_s), .uptime(up_s)
  );

  rst_seq #(.SYNC_STAGES(2), .NUM_OUT(1), .STAGE_DELAY(1), .CNT_W(16)) dut_m (
    .clk(clk), .rstn(rstn), .sw_rst_req(sw_rst_req),
    .rst_out_n(ro_m), .ready(rdy_m), .busy(bsy_m), .uptime(up_m)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, e, act, exp);
    end
  endtask

  function automatic int ready_edge(int k);
    return base_m[k] + P_N[k] * P_D[k];
  endfunction

  function automatic logic [2:0] exp_ro(int k);
    logic [2:0] r = '0;
    for (int i = 0; i < P_N[k]; i++) r[i] = (n_m[k] >= base_m[k] + (i + 1) * P_D[k]);
    return r;
  endfunction

  function automatic int exp_up(int k);
    int r   = ready_edge(k);
    int sat = (1 << P_W[k]) - 1;
    if (n_m[k] < r) return 0;
    return (n_m[k] - r > sat) ? sat : n_m[k] - r;
  endfunction

  // Model update: a request counts only if the DUT was already in RUN.
  initial forever begin
    @(posedge clk or negedge rstn);
    for (int k = 0; k < 3; k++) begin
      if (!rstn) begin
        n_m[k]    = 0;
        base_m[k] = SYNC;
      end else begin
        n_m[k] = n_m[k] + 1;
        if (sw_rst_req && (n_m[k] > ready_edge(k))) base_m[k] = n_m[k] + P_D[k];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        logic [2:0]  ro;
        logic        rdy, bsy;
        logic [15:0] up;
        case (k)
          0:       begin ro = ro_a;          rdy = rdy_a; bsy = bsy_a; up = up_a;           end
          1:       begin ro = ro_s;          rdy = rdy_s; bsy = bsy_s; up = {12'h000, up_s}; end
          default: begin ro = {2'b00, ro_m}; rdy = rdy_m; bsy = bsy_m; up = up_m;           end
        endcase
        chk({NM[k], " rst_out_n"}, ro, exp_ro(k));
        chk({NM[k], " ready"}, rdy, n_m[k] >= ready_edge(k));
        chk({NM[k], " busy"}, bsy, n_m[k] < ready_edge(k));
        chk({NM[k], " uptime"}, up, exp_up(k));
      end
    end
  end

  task automatic pin_phase1();
    case (e)
      2:  chk("M rst_out_n pre", ro_m, 1'b0);
      3:  begin chk("M rst_out_n @3", ro_m, 1'b1); chk("M ready @3", rdy_m, 1'b1); end
      4:  chk("M uptime @4", up_m, 1);
      5:  chk("M sw reset @5", ro_m, 1'b0);
      9:  chk("A rst_out_n @9", ro_a, 3'b000);
      10: chk("A rst_out_n @10", ro_a, 3'b001);
      17: chk("A rst_out_n @17", ro_a, 3'b001);
      18: chk("A rst_out_n @18", ro_a, 3'b011);
      25: begin chk("A rst_out_n @25", ro_a, 3'b011); chk("A ready @25", rdy_a, 1'b0); end
      26: begin
        chk("A rst_out_n @26", ro_a, 3'b111); chk("A ready @26", rdy_a, 1'b1);
        chk("A busy @26", bsy_a, 1'b0);       chk("A uptime @26", up_a, 0);
        chk("S rst_out_n @26", ro_s, 3'b111);
      end
      27: chk("A uptime @27", up_a, 1);
      39: chk("S uptime @39", up_s, 13);
      40: begin
        chk("A sw rst_out_n @40", ro_a, 3'b000); chk("A sw ready @40", rdy_a, 1'b0);
        chk("A sw busy @40", bsy_a, 1'b1);       chk("A sw uptime @40", up_a, 0);
      end
      55: chk("A rst_out_n @55", ro_a, 3'b000);
      56: chk("A rst_out_n @56", ro_a, 3'b001);
      63: chk("A rst_out_n @63", ro_a, 3'b001);
      64: chk("A rst_out_n @64", ro_a, 3'b011);
      71: begin chk("A rst_out_n @71", ro_a, 3'b011); chk("A ready @71", rdy_a, 1'b0); end
      72: begin chk("A rst_out_n @72", ro_a, 3'b111); chk("A ready @72", rdy_a, 1'b1); end
      86: chk("S uptime @86", up_s, 14);
      87: chk("S uptime @87", up_s, 15);
      100: begin chk("S uptime sat @100", up_s, 15); chk("A uptime @100", up_a, 28); end
      default: ;
    endcase
  endtask

  task automatic pin_restart();
    case (e)
      9:  chk("A restart @9", ro_a, 3'b000);
      10: chk("A restart @10", ro_a, 3'b001);
      18: chk("A restart @18", ro_a, 3'b011);
      26: begin chk("A restart @26", ro_a, 3'b111); chk("A restart ready @26", rdy_a, 1'b1); end
      default: ;
    endcase
  endtask

  initial begin
    rstn       = 1'b1;
    sw_rst_req = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("A async reset rst_out_n", ro_a, 3'b000);
    chk("A async reset busy", bsy_a, 1'b1);
    chk_en = 1'b1;

    // Power-on, with a request held through RELEASE and one request in RUN.
    repeat (10) @(posedge clk);
    #2 rstn = 1'b1;
    e = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      pin_phase1();
      if (e == 4)  sw_rst_req = 1'b1;
      if (e == 20) sw_rst_req = 1'b0;
      if (e == 39) sw_rst_req = 1'b1;
      if (e == 40) sw_rst_req = 1'b0;
    end

    // Board reset from RUN clears everything without a clock edge.
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("A rstn in RUN rst_out_n", ro_a, 3'b000);
    chk("A rstn in RUN ready", rdy_a, 1'b0);
    chk("A rstn in RUN uptime", up_a, 0);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    e = 0;
    repeat (15) begin
      @(posedge clk);
      e++;
    end

    // Sub-cycle glitch between the bit-0 and bit-1 releases.
    #1 chk("A before glitch", ro_a, 3'b001);
    #1 rstn = 1'b0;
    #1;
    chk("A glitch rst_out_n", ro_a, 3'b000);
    chk("A glitch busy", bsy_a, 1'b1);
    chk("M glitch ready", rdy_m, 1'b0);
    #1 rstn = 1'b1;
    e = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      pin_restart();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
